// File: rtl/adder_32bit_accum_pkg.sv
// Shared definitions for the burst accumulator: FSM state encoding and default widths.
package adder_32bit_accum_pkg;

    localparam int DEFAULT_CNT_W   = 8;
    localparam int DEFAULT_CARRY_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } acc_state_e;

endpackage

// File: rtl/adder_32bit_accum_if.sv
// Burst command, input stream and result stream of the accumulator in one bundle.
interface adder_32bit_accum_if
    import adder_32bit_accum_pkg::*;
#(
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int CARRY_W = DEFAULT_CARRY_W
) ();

    logic               start;
    logic [CNT_W-1:0]   len;
    logic               in_valid;
    logic [32:1]        in_data;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [32:1]        out_sum;
    logic [CARRY_W-1:0] out_carry;
    logic               out_ovf;
    logic               busy;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_ovf, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_ovf, busy
    );

endinterface

// File: rtl/adder_32bit.sv
// Plain 32-bit combinational adder; S is the low word and C32 the carry out of bit 32.
module adder_32bit (
    input  logic [32:1] A,
    input  logic [32:1] B,
    output logic [32:1] S,
    output logic        C32
);

    assign {C32, S} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/adder_32bit_accum.sv
// Burst accumulator: sums LEN words through one adder_32bit, counts carry-outs as the
// high-order extension of the total and hands the result out on a valid/ready port.
module adder_32bit_accum
    import adder_32bit_accum_pkg::*;
#(
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int CARRY_W = DEFAULT_CARRY_W
) (
    input  logic                clk,
    input  logic                rst,
    adder_32bit_accum_if.slave  bus
);

    acc_state_e         state_q, state_d;
    logic [32:1]        acc_q, acc_d;
    logic [CARRY_W-1:0] carry_q, carry_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               ovf_q, ovf_d;

    logic [32:1]        add_s;
    logic               add_c32;

    adder_32bit u_add (
        .A   (acc_q),
        .B   (bus.in_data),
        .S   (add_s),
        .C32 (add_c32)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    carry_d = '0;
                    ovf_d   = 1'b0;
                    rem_d   = bus.len;
                    // An empty burst skips RUN and reports an all-zero total.
                    state_d = (bus.len != '0) ? ST_RUN : ST_HOLD;
                end
            end
            ST_RUN: begin
                if (bus.in_valid) begin
                    acc_d   = add_s;
                    carry_d = carry_q + CARRY_W'(add_c32);
                    if ((&carry_q) && add_c32)
                        ovf_d = 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1))
                        state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            carry_q <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs decode the registered state only, never in_valid.
    assign bus.in_ready  = (state_q == ST_RUN);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_sum   = acc_q;
    assign bus.out_carry = carry_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_32bit_accum.sv
// Scoreboard bench for adder_32bit_accum: bursts are modelled as plain integer sums and
// results are checked by an independent monitor on each output handshake.
module tb_adder_32bit_accum;

    localparam int CNT_W   = 8;
    localparam int CARRY_W = 2;

    typedef struct {
        logic [31:0]        sum;
        logic [CARRY_W-1:0] carry;
        logic               ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    logic force_low = 1'b0;
    logic rand_bp   = 1'b0;
    logic rdy_rand  = 1'b1;

    adder_32bit_accum_if #(.CNT_W(CNT_W), .CARRY_W(CARRY_W)) bus ();

    adder_32bit_accum #(.CNT_W(CNT_W), .CARRY_W(CARRY_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.out_ready = force_low ? 1'b0 : rdy_rand;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rdy_rand = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: the whole burst as one wide integer sum.
    function automatic exp_t model(input logic [31:0] w[$]);
        exp_t e;
        logic [63:0] tot = 64'd0;
        logic [63:0] hi;
        foreach (w[i]) tot += {32'd0, w[i]};
        hi      = tot >> 32;
        e.sum   = tot[31:0];
        e.carry = hi[CARRY_W-1:0];
        e.ovf   = (hi >= (64'd1 << CARRY_W));
        return e;
    endfunction

    // Monitor: pops on every result handshake and checks hold stability under backpressure.
    logic        pend = 1'b0;
    logic [31:0] h_sum;
    logic [7:0]  h_carry;
    logic        h_ovf;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
                    if (bus.out_valid) begin
                        chk("hold_sum", {32'd0, bus.out_sum}, {32'd0, h_sum});
                        chk("hold_carry", {62'd0, bus.out_carry}, {56'd0, h_carry});
                        chk("hold_ovf", {63'd0, bus.out_ovf}, {63'd0, h_ovf});
                    end
                end
                pend = 1'b0;
                if (bus.out_valid) begin
                    if (bus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_result", 64'd1, 64'd0);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            chk("out_sum", {32'd0, bus.out_sum}, {32'd0, e.sum});
                            chk("out_carry", {62'd0, bus.out_carry}, {62'd0, e.carry});
                            chk("out_ovf", {63'd0, bus.out_ovf}, {63'd0, e.ovf});
                        end
                    end else begin
                        pend    = 1'b1;
                        h_sum   = bus.out_sum;
                        h_carry = 8'(bus.out_carry);
                        h_ovf   = bus.out_ovf;
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int n);
        bus.start = 1'b1;
        bus.len   = CNT_W'(n);
        tick();
        bus.start = 1'b0;
    endtask

    // Presents one word and holds it until the accepting edge; returns 1 if accepted.
    task automatic send_word(input logic [31:0] w, output bit ok);
        bit acc;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        if (!ok) chk("beat_timeout", 64'd1, 64'd0);
    endtask

    task automatic gap(input int pct);
        while ($urandom_range(0, 99) < pct) tick();
    endtask

    task automatic send_beats(input logic [31:0] w[$], input int pct, input int n_last);
        bit ok;
        int cnt = 0;
        foreach (w[i]) begin
            if (i >= n_last) break;
            gap(pct);
            send_word(w[i], ok);
            if (ok) cnt++;
        end
        chk("beat_count", 64'(cnt), 64'(n_last));
    endtask

    task automatic check_done_latency;
        @(negedge clk);
        chk("valid_after_last", {63'd0, bus.out_valid}, 64'd1);
        chk("ready_after_last", {63'd0, bus.in_ready}, 64'd0);
    endtask

    task automatic wait_idle;
        bit done = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!bus.busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("idle_timeout", 64'd1, 64'd0);
        tick();
    endtask

    task automatic run_burst(input logic [31:0] w[$], input int pct);
        exp_q.push_back(model(w));
        start_burst(w.size());
        send_beats(w, pct, w.size());
        check_done_latency();
        wait_idle();
    endtask

    initial begin
        logic [31:0] w[$];
        bit ok;
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        #2;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_out_sum", {32'd0, bus.out_sum}, 64'd0);
        chk("rst_out_carry", {62'd0, bus.out_carry}, 64'd0);
        chk("rst_out_ovf", {63'd0, bus.out_ovf}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();

        w = '{32'd1, 32'd2, 32'd3};
        run_burst(w, 0);
        w = '{32'hFFFFFFFF, 32'h00000002};
        run_burst(w, 0);
        w = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        run_burst(w, 0);

        // Empty burst goes straight to HOLD without ever opening the input.
        w = {};
        exp_q.push_back(model(w));
        start_burst(0);
        @(negedge clk);
        chk("len0_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("len0_in_ready", {63'd0, bus.in_ready}, 64'd0);
        wait_idle();

        // Gaps, stray starts in RUN/HOLD, and five cycles of backpressure.
        w = '{32'h12345678, 32'h9ABCDEF0, 32'hF0000001};
        force_low = 1'b1;
        exp_q.push_back(model(w));
        start_burst(3);
        tick();
        send_word(w[0], ok);
        tick();
        bus.start = 1'b1;
        bus.len   = CNT_W'(1);
        tick();
        bus.start = 1'b0;
        send_word(w[1], ok);
        tick();
        send_word(w[2], ok);
        check_done_latency();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        force_low = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("start_at_handshake_ignored", {63'd0, bus.busy}, 64'd0);
        chk("idle_out_valid", {63'd0, bus.out_valid}, 64'd0);
        tick();

        // Reset in the middle of a burst: nothing is emitted for it.
        w = '{32'hAAAA0000, 32'h5555FFFF, 32'd9, 32'd10};
        start_burst(4);
        send_beats(w, 0, 2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
        chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midrst_out_sum", {32'd0, bus.out_sum}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        w = '{32'd7};
        run_burst(w, 0);

        rand_bp = 1'b1;
        for (int b = 0; b < 25; b++) begin
            int n = $urandom_range(1, 12);
            w = {};
            for (int i = 0; i < n; i++)
                w.push_back(($urandom_range(0, 2) == 0) ? (32'hFFFFFF00 | 32'($urandom_range(0, 255)))
                                                        : $urandom);
            run_burst(w, 30);
        end
        rand_bp = 1'b0;

        repeat (3) tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
